// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg: shared state encoding and default sizing for clock_monitor.
package clock_monitor_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int TIMEOUT_DEF = 1000;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser plus delay flop giving rise/fall pulses and the synced level.
module sync_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic sig_in,
  output logic rise,
  output logic fall,
  output logic level
);
  logic s1, s2, s3;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {sig_in, s1, s2};
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign level = s2;
endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: measures period, high time and rising-edge count of a slow asynchronous clock, flags a stuck input.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck,
  output logic [CNT_W-1:0] edge_count
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  state_t state;
  logic [CNT_W-1:0] counter, count_next;
  logic rise, fall, level_unused;
  sync_edge_detect u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall),
    .level  (level_unused)
  );
  // saturate rather than wrap so a dead input keeps reporting stuck
  assign count_next = (counter == LIMIT) ? LIMIT : counter + CNT_W'(1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      counter <= '0;
      period <= '0;
      high_time <= '0;
      edge_count <= '0;
      stuck <= 1'b0;
      valid <= 1'b0;
    end else if (clear) begin
      state <= enable ? ARM : IDLE;
      counter <= '0;
      period <= '0;
      high_time <= '0;
      edge_count <= '0;
      stuck <= 1'b0;
      valid <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      counter <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: state <= ARM;
        ARM:
          if (rise) begin
            counter <= CNT_W'(1);
            edge_count <= edge_count + CNT_W'(1);
            stuck <= 1'b0;
            state <= MEASURE;
          end else begin
            counter <= count_next;
            if (counter == LIMIT) stuck <= 1'b1;
          end
        MEASURE:
          if (rise) begin
            period <= counter;
            valid <= 1'b1;
            edge_count <= edge_count + CNT_W'(1);
            counter <= CNT_W'(1);
            stuck <= 1'b0;
          end else begin
            counter <= count_next;
            if (fall) high_time <= counter;
            if (counter == LIMIT) begin
              stuck <= 1'b1;
              state <= ARM;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule
